// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multi-cycle multiply/divide unit.
// Holds the op codes, FSM states and small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_divide_step.sv
// divide_step: one combinational restoring-division step.
// Shifts the next dividend bit into the remainder and subtracts if it fits.
module divide_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Trial subtract; the top bit of diff is the borrow while rem_i < div_i.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial - {1'b0, div_i};
        q_o   = ~diff[WIDTH];
        rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide owning the HI/LO pair.
// Define MULDIV_MULT_EN to build the MULT/MULTU shift-add datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             op_ok;
    logic             accept;
    logic             sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fix, r_fix;
`ifdef MULDIV_MULT_EN
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
`endif

    divide_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (acc_q),
        .div_i (dvs_q),
        .bit_i (quo_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Issue decode: operand magnitudes and result signs for signed ops.
    always_comb begin
`ifdef MULDIV_MULT_EN
        op_ok = 1'b1;
`else
        op_ok = op_is_div(op);
`endif
        accept = start && !flush && (state_q == ST_IDLE) && op_ok;
        sa     = op_is_signed(op) & operand_a[WIDTH-1];
        sb     = op_is_signed(op) & operand_b[WIDTH-1];
        abs_a  = sa ? -operand_a : operand_a;
        abs_b  = sb ? -operand_b : operand_b;
        q_fix  = qneg_q ? -quo_q : quo_q;
        r_fix  = rneg_q ? -acc_q : acc_q;
    end

    // Next-state, iteration datapath and commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef MULDIV_MULT_EN
        sum     = '0;
        prod    = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    div_d   = op_is_div(op);
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    acc_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    dbz_d   = 1'b0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (div_q) begin
                    acc_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_q};
                end
`ifdef MULDIV_MULT_EN
                else begin
                    sum   = {1'b0, acc_q}
                          + (quo_q[0] ? {1'b0, dvs_q} : '0);
                    acc_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
`endif
                if (cnt_q == LAST) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // Zero divisor: remainder already equals |a|.
                    dbz_d = (dvs_q == '0);
                    hi_d  = r_fix;
                    lo_d  = (dvs_q == '0) ? '1 : q_fix;
                end
`ifdef MULDIV_MULT_EN
                else begin
                    prod = qneg_q ? -{acc_q, quo_q} : {acc_q, quo_q};
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = dbz_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
